// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate decode behind a valid/ready output register plus one skid entry,
// with a saturating debug count of accepted unknown opcodes.
module imm_gen_stage #(
    parameter int XLEN         = 64,
    parameter bit BYTE_OFFSETS = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    input  logic             clear_count,
    output logic [CNT_W-1:0] unk_count
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    logic signed [31:0] raw, adj;
    logic [XLEN-1:0]    dec_imm;
    logic [2:0]         dec_fmt;
    logic               dec_ill;
    logic               acc, load;

    logic             out_v_q, out_v_d, out_ill_q, out_ill_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_fmt_q, out_fmt_d;
    logic             sk_v_q, sk_v_d, sk_ill_q, sk_ill_d;
    logic [XLEN-1:0]  sk_imm_q, sk_imm_d;
    logic [2:0]       sk_fmt_q, sk_fmt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        raw     = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: begin
                dec_fmt = FMT_I;
                raw     = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                raw     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                raw     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                raw     = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                raw     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: dec_ill = 1'b0;
            default: dec_ill = 1'b1;
        endcase
    end

    // halfword-count mode only rescales the branch/jump offsets
    assign adj     = (!BYTE_OFFSETS && (dec_fmt == FMT_B || dec_fmt == FMT_J)) ? raw >>> 1 : raw;
    assign dec_imm = XLEN'(adj);

    assign in_ready = !sk_v_q;
    assign acc      = in_valid && in_ready;
    assign load     = !out_v_q || out_ready;

    always_comb begin
        out_v_d   = out_v_q;
        out_imm_d = out_imm_q;
        out_fmt_d = out_fmt_q;
        out_ill_d = out_ill_q;
        sk_v_d    = sk_v_q;
        sk_imm_d  = sk_imm_q;
        sk_fmt_d  = sk_fmt_q;
        sk_ill_d  = sk_ill_q;
        if (flush) begin
            out_v_d = 1'b0;
            sk_v_d  = 1'b0;
        end else if (load && sk_v_q) begin
            out_v_d   = 1'b1;
            out_imm_d = sk_imm_q;
            out_fmt_d = sk_fmt_q;
            out_ill_d = sk_ill_q;
            sk_v_d    = 1'b0;
        end else if (load) begin
            out_v_d = acc;
            if (acc) begin
                out_imm_d = dec_imm;
                out_fmt_d = dec_fmt;
                out_ill_d = dec_ill;
            end
        end else if (acc) begin
            sk_v_d   = 1'b1;
            sk_imm_d = dec_imm;
            sk_fmt_d = dec_fmt;
            sk_ill_d = dec_ill;
        end
        cnt_d = clear_count ? '0 : (acc && dec_ill && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_v_q   <= 1'b0;
            out_imm_q <= '0;
            out_fmt_q <= FMT_NONE;
            out_ill_q <= 1'b0;
            sk_v_q    <= 1'b0;
            sk_imm_q  <= '0;
            sk_fmt_q  <= FMT_NONE;
            sk_ill_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            out_v_q   <= out_v_d;
            out_imm_q <= out_imm_d;
            out_fmt_q <= out_fmt_d;
            out_ill_q <= out_ill_d;
            sk_v_q    <= sk_v_d;
            sk_imm_q  <= sk_imm_d;
            sk_fmt_q  <= sk_fmt_d;
            sk_ill_q  <= sk_ill_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = out_v_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_ill_q;
    assign unk_count   = cnt_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed scoreboard bench; the default instance is tracked through a queue,
// alternate parameterisations are spot-checked directly.
module tb_imm_gen_stage;
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_count = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  unk_count;

    logic        b0_ready, b0_valid, b0_ill;
    logic [63:0] b0_imm;
    logic [2:0]  b0_fmt;
    logic [7:0]  b0_cnt;
    logic        x32_ready, x32_valid, x32_ill;
    logic [31:0] x32_imm;
    logic [2:0]  x32_fmt;
    logic [7:0]  x32_cnt;
    logic        c2_ready, c2_valid, c2_ill;
    logic [63:0] c2_imm;
    logic [2:0]  c2_fmt;
    logic [1:0]  c2_cnt;

    exp_t q[$];
    exp_t p, f;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .clear_count(clear_count), .unk_count(unk_count)
    );
    imm_gen_stage #(.XLEN(64), .BYTE_OFFSETS(1'b0), .CNT_W(8)) dut_b0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b0_ready), .in_inst(in_inst),
        .flush(flush), .out_valid(b0_valid), .out_ready(out_ready), .out_imm(b0_imm),
        .out_fmt(b0_fmt), .out_illegal(b0_ill), .clear_count(clear_count), .unk_count(b0_cnt)
    );
    imm_gen_stage #(.XLEN(32), .BYTE_OFFSETS(1'b1), .CNT_W(8)) dut_32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(x32_ready), .in_inst(in_inst),
        .flush(flush), .out_valid(x32_valid), .out_ready(out_ready), .out_imm(x32_imm),
        .out_fmt(x32_fmt), .out_illegal(x32_ill), .clear_count(clear_count), .unk_count(x32_cnt)
    );
    imm_gen_stage #(.XLEN(64), .BYTE_OFFSETS(1'b1), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c2_ready), .in_inst(in_inst),
        .flush(flush), .out_valid(c2_valid), .out_ready(out_ready), .out_imm(c2_imm),
        .out_fmt(c2_fmt), .out_illegal(c2_ill), .clear_count(clear_count), .unk_count(c2_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] inst, input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        in_valid = 1'b1;
        in_inst  = inst;
        p.imm = imm;
        p.fmt = fmt;
        p.ill = ill;
    endtask

    // called at a falling edge with inputs settled; scores the coming rising edge
    task automatic step();
        logic acc, pop;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (pop) begin
            n_vec++;
            assert (q.size() != 0) else begin
                n_bad++;
                $error("FAIL spurious_out: observed imm %h with empty scoreboard expected none", out_imm);
            end
            if (q.size() != 0) begin
                f = q.pop_front();
                chk("sb_imm", out_imm, f.imm);
                chk("sb_fmt", 64'(out_fmt), 64'(f.fmt));
                chk("sb_ill", 64'(out_illegal), 64'(f.ill));
            end
        end
        if (flush) q.delete();
        else if (acc) q.push_back(p);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_ill", 64'(out_illegal), 64'd0);
        chk("rst_cnt", 64'(unk_count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        out_ready = 1'b1;
        put(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        step();
        chk("latency_valid", 64'(out_valid), 64'd1);
        put(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
        step();
        chk("beq_b0_imm", b0_imm, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("beq_x32_imm", 64'(x32_imm), 64'h0000_0000_FFFF_FFFC);
        chk("beq_x32_fmt", 64'(x32_fmt), 64'd3);
        put(32'h0020B423, 64'h8, 3'd2, 1'b0);
        step();
        put(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        step();
        put(32'h0080006F, 64'h8, 3'd5, 1'b0);
        step();
        chk("jal_b0_imm", b0_imm, 64'h4);
        put(32'h002081B3, 64'h0, 3'd0, 1'b0);
        step();
        chk("thru_valid", 64'(out_valid), 64'd1);
        idle();
        idle();
        chk("thru_drained", 64'(q.size()), 64'd0);
        chk("legal_cnt", 64'(unk_count), 64'd0);

        out_ready = 1'b0;
        put(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        step();
        chk("bp_ready_one", 64'(in_ready), 64'd1);
        put(32'h0020B423, 64'h8, 3'd2, 1'b0);
        step();
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        put(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        step();
        chk("bp_ready_held", 64'(in_ready), 64'd0);
        chk("bp_hold_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bp_hold_fmt", 64'(out_fmt), 64'd1);
        out_ready = 1'b1;
        step();
        step();
        idle();
        chk("bp_out_c", out_imm, 64'hFFFF_FFFF_8000_0000);
        idle();
        chk("bp_drained", 64'(q.size()), 64'd0);

        for (int i = 0; i < 3; i++) begin
            put(32'h0000007F, 64'h0, 3'd0, 1'b1);
            step();
        end
        idle();
        chk("ill_cnt3", 64'(unk_count), 64'd3);
        chk("ill_c2_cnt3", 64'(c2_cnt), 64'd3);
        clear_count = 1'b1;
        put(32'h0000007F, 64'h0, 3'd0, 1'b1);
        step();
        clear_count = 1'b0;
        chk("clr_prio", 64'(unk_count), 64'd0);
        chk("clr_prio_c2", 64'(c2_cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            put(32'h0000007F, 64'h0, 3'd0, 1'b1);
            step();
        end
        idle();
        chk("sat_c2", 64'(c2_cnt), 64'd3);
        chk("cnt5", 64'(unk_count), 64'd5);

        out_ready = 1'b0;
        put(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        step();
        put(32'h0020B423, 64'h8, 3'd2, 1'b0);
        step();
        flush = 1'b1;
        put(32'h0080006F, 64'h8, 3'd5, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        idle();
        chk("flush_no_word", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        put(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        step();
        flush = 1'b1;
        put(32'h0000007F, 64'h0, 3'd0, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_acc_valid", 64'(out_valid), 64'd0);
        chk("flush_acc_cnt", 64'(unk_count), 64'd6);
        out_ready = 1'b1;
        idle();
        chk("flush_acc_gone", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        put(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        step();
        put(32'h0020B423, 64'h8, 3'd2, 1'b0);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_imm", out_imm, 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_cnt", 64'(unk_count), 64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        put(32'h0080006F, 64'h8, 3'd5, 1'b0);
        step();
        idle();
        chk("post_rst_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
